color_sequence_checker: RTL
===========================

Name: color_sequence_checker

Overview:
- Frame-level controller that sits downstream of the four-region color tracker and sequences a "repeat the pattern" round.
- Enables the tracker and samples its 4-bit per-region detection once per frame.
- Debounces the detection across frames and turns stable single-region detections into press events.
- Checks the presses against a loaded target sequence and reports pass, fail or timeout.

Parameters:
SEQ_LEN_MAX, 16, depth of target-sequence memory (addr width 4, length width 5)
STABLE_FRAMES, 3, consecutive identical frame samples required before a detection code is accepted (>=1)
TIMEOUT_FRAMES, 300, frames allowed in WAIT_PRESS before timeout fail (counter width clog2(TIMEOUT_FRAMES+1))

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_end  in  1  one-cycle pulse after the last active pixel of a frame, when detected[] is final for that frame
detected  in  4  per-region detection from tracker (bit0 red, bit1 green, bit2 blue, bit3 yellow)
tracker_en  out  1  tracker enable; low holds the tracker cleared
load_we  in  1  write strobe for target memory
load_addr  in  4  target memory address
load_color  in  2  color code written (0 red, 1 green, 2 blue, 3 yellow)
seq_len  in  5  round length, sampled on start
start  in  1  one-cycle round start request
busy  out  1  round in progress
step_idx  out  4  index of next expected press
press_valid  out  1  one-cycle pulse per accepted press
press_color  out  2  color of accepted press, valid with press_valid
pass  out  1  level, round completed correctly
fail  out  1  level, wrong press or timeout
timeout  out  1  level, qualifies fail as timeout

Behaviour:
Reset (async, rst_n=0):
- All outputs 0, state IDLE.
- Debounce history and counters cleared.
- Target memory contents undefined (no reset required).

Target memory:
- load_we writes mem[load_addr] <= load_color at posedge, only while busy=0.
- Writes while busy are ignored.

start:
- Accepted only in IDLE, DONE_PASS or DONE_FAIL, and only when 1 <= seq_len <= SEQ_LEN_MAX. Otherwise ignored, with no output change.
- On accept:
  - latch seq_len;
  - step_idx <= 0;
  - clear pass/fail/timeout;
  - clear debounce history;
  - busy <= 1, tracker_en <= 1;
  - go to WAIT_RELEASE.
- A frame_end in the same cycle as an accepted start is ignored.

Debounce (frame_end cycles only, while busy):
- sample = detected.
- If sample == last_sample, stable_cnt <= min(stable_cnt+1, STABLE_FRAMES); else stable_cnt <= 1.
- last_sample <= sample.
- The code is "stable" when the updated stable_cnt >= STABLE_FRAMES.

States:
- IDLE / DONE_PASS / DONE_FAIL: busy=0, tracker_en=0. Only start is acted on.
- WAIT_RELEASE: on a frame_end that makes code 0000 stable -> WAIT_PRESS, timeout counter cleared.
- WAIT_PRESS:
  - Each frame_end increments the timeout counter.
  - Stable one-hot code -> press accepted:
    - press_valid=1 and press_color=encoded bit, one cycle after that frame_end;
    - compare with mem[step_idx];
    - match and step_idx==seq_len-1 -> pass=1, go DONE_PASS;
    - match otherwise -> step_idx+1, go WAIT_RELEASE, debounce history cleared;
    - mismatch -> fail=1, go DONE_FAIL.
  - Stable multi-bit or zero code -> no press; remain.
  - If no press is accepted and the counter reaches TIMEOUT_FRAMES -> fail=1, timeout=1, go DONE_FAIL.
  - If a press and a timeout occur on the same frame_end, the press wins.

Outputs and timing:
- pass/fail/timeout hold until the next accepted start or reset.
- press_valid is still pulsed for a failing press.
- All outputs are registered. Latency from the deciding frame_end to press_valid/pass/fail/state change is 1 cycle.
- Reset asserted mid-round aborts immediately to IDLE with all outputs 0.

Test Plan:
- Load mem=[1,3,0], seq_len=3, start; hold detected=0000 for 3 frames, then 0010 for 3 frames -> press_valid with press_color=1 one cycle after 3rd frame_end, step_idx=1. Repeat with 1000 and 0001 (releasing between presses) -> pass=1, busy=0, tracker_en=0.
- Same load; first press 0100 stable 3 frames -> press_valid, press_color=2, fail=1, timeout=0, step_idx stays 0.
- detected alternates 0010/0000 every frame in WAIT_PRESS -> no press_valid. Stable 0110 for 5 frames -> no press, state stays WAIT_PRESS.
- TIMEOUT_FRAMES=4, no detections -> fail=1, timeout=1 one cycle after 4th frame_end in WAIT_PRESS. Next start clears both.
- start with seq_len=0 and with seq_len=17 -> ignored, busy stays 0. load_we while busy -> memory unchanged (checked by subsequent round).
- Assert rst_n=0 mid-round after step_idx=1 -> all outputs 0 immediately, without waiting for a clock. After release, a new start begins at step_idx=0 in WAIT_RELEASE.

Source files
------------

// File: rtl/color_sequence_checker.sv
// color_sequence_checker
//   Frame-level round controller placed after the four-region color tracker.
//   It enables the tracker during a round and samples the per-region detection
//   once per frame. Detections must stay identical for STABLE_FRAMES frames
//   before they count. A stable one-hot code is a press, and each press is
//   checked against a loaded target sequence. The round ends in pass, in fail
//   (wrong press) or in fail+timeout (no press within TIMEOUT_FRAMES frames).
//
// Ports
//   clk          system/pixel clock
//   rst_n        asynchronous active-low reset
//   frame_end    one-cycle pulse; detected[] is final for the frame
//   detected     per-region detection (bit0 red, bit1 green, bit2 blue, bit3 yellow)
//   tracker_en   tracker enable, high while a round is in progress
//   load_we      target memory write strobe (ignored while busy)
//   load_addr    target memory address
//   load_color   color code written (0 red, 1 green, 2 blue, 3 yellow)
//   seq_len      round length, sampled on an accepted start
//   start        one-cycle round start request
//   busy         round in progress
//   step_idx     index of the next expected press
//   press_valid  one-cycle pulse per accepted press
//   press_color  color of the accepted press, valid with press_valid
//   pass         level, round completed correctly
//   fail         level, wrong press or timeout
//   timeout      level, qualifies fail as a timeout
module color_sequence_checker #(
    parameter int SEQ_LEN_MAX    = 16,
    parameter int STABLE_FRAMES  = 3,
    parameter int TIMEOUT_FRAMES = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic [3:0] detected,
    output logic       tracker_en,
    input  logic       load_we,
    input  logic [3:0] load_addr,
    input  logic [1:0] load_color,
    input  logic [4:0] seq_len,
    input  logic       start,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       press_valid,
    output logic [1:0] press_color,
    output logic       pass,
    output logic       fail,
    output logic       timeout
);

    localparam int SCW = $clog2(STABLE_FRAMES + 1);
    localparam int TW  = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_FRAMES);
    localparam logic [SCW-1:0] STABLE_ONE  = SCW'(1);
    localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_FRAMES);
    localparam logic [TW-1:0]  TIMEOUT_ONE = TW'(1);
    localparam logic [5:0]     LEN_MAX     = 6'(SEQ_LEN_MAX);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd1;
    localparam logic [2:0] ST_WAIT_PRESS   = 3'd2;
    localparam logic [2:0] ST_DONE_PASS    = 3'd3;
    localparam logic [2:0] ST_DONE_FAIL    = 3'd4;

    // True when exactly one region reports a detection.
    function automatic logic is_onehot4(input logic [3:0] code);
        return (code != 4'd0) && ((code & (code - 4'd1)) == 4'd0);
    endfunction

    // Color code of a one-hot detection; only meaningful for one-hot input.
    function automatic logic [1:0] encode4(input logic [3:0] code);
        logic [1:0] idx;
        idx = 2'd0;
        case (code)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [1:0]     mem_r [SEQ_LEN_MAX];
    logic [2:0]     state_r,        state_s;
    logic [4:0]     seq_len_r,      seq_len_s;
    logic [3:0]     step_idx_r,     step_idx_s;
    logic [3:0]     last_sample_r,  last_sample_s;
    logic [SCW-1:0] stable_cnt_r,   stable_cnt_s;
    logic [TW-1:0]  timeout_cnt_r,  timeout_cnt_s;
    logic           busy_r,         busy_s;
    logic           tracker_en_r,   tracker_en_s;
    logic           press_valid_r,  press_valid_s;
    logic [1:0]     press_color_r,  press_color_s;
    logic           pass_r,         pass_s;
    logic           fail_r,         fail_s;
    logic           timeout_r,      timeout_s;

    logic           start_ok_s;
    logic           frame_s;
    logic [SCW-1:0] cnt_upd_s;
    logic           stable_s;
    logic [1:0]     code_color_s;
    logic [TW-1:0]  timeout_inc_s;

    // Target memory write port; no reset, writes only between rounds.
    always_ff @(posedge clk) begin
        if (load_we && !busy_r && ({2'b00, load_addr} < LEN_MAX)) begin
            mem_r[load_addr] <= load_color;
        end
    end

    // Qualifiers for start and frame events plus the updated debounce count.
    always_comb begin
        start_ok_s = start && !busy_r && (seq_len != 5'd0) &&
                     ({1'b0, seq_len} <= LEN_MAX);
        frame_s    = frame_end && busy_r;
        if (detected != last_sample_r) begin
            cnt_upd_s = STABLE_ONE;
        end else if (stable_cnt_r >= STABLE_MAX) begin
            cnt_upd_s = STABLE_MAX;
        end else begin
            cnt_upd_s = stable_cnt_r + STABLE_ONE;
        end
        stable_s      = (cnt_upd_s >= STABLE_MAX);
        code_color_s  = encode4(detected);
        timeout_inc_s = timeout_cnt_r + TIMEOUT_ONE;
    end

    // Round sequencing: next values for every registered output and state.
    always_comb begin
        state_s       = state_r;
        seq_len_s     = seq_len_r;
        step_idx_s    = step_idx_r;
        last_sample_s = last_sample_r;
        stable_cnt_s  = stable_cnt_r;
        timeout_cnt_s = timeout_cnt_r;
        busy_s        = busy_r;
        tracker_en_s  = tracker_en_r;
        press_valid_s = 1'b0;
        press_color_s = press_color_r;
        pass_s        = pass_r;
        fail_s        = fail_r;
        timeout_s     = timeout_r;

        if (start_ok_s) begin
            seq_len_s     = seq_len;
            step_idx_s    = 4'd0;
            pass_s        = 1'b0;
            fail_s        = 1'b0;
            timeout_s     = 1'b0;
            last_sample_s = 4'd0;
            stable_cnt_s  = '0;
            busy_s        = 1'b1;
            tracker_en_s  = 1'b1;
            state_s       = ST_WAIT_RELEASE;
        end else if (frame_s) begin
            last_sample_s = detected;
            stable_cnt_s  = cnt_upd_s;
            case (state_r)
                ST_WAIT_RELEASE: begin
                    if (stable_s && (detected == 4'd0)) begin
                        timeout_cnt_s = '0;
                        state_s       = ST_WAIT_PRESS;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_WAIT_PRESS: begin
                    timeout_cnt_s = timeout_inc_s;
                    // A press on the deciding frame takes priority over timeout.
                    if (stable_s && is_onehot4(detected)) begin
                        press_valid_s = 1'b1;
                        press_color_s = code_color_s;
                        if (code_color_s == mem_r[step_idx_r]) begin
                            if ({1'b0, step_idx_r} == (seq_len_r - 5'd1)) begin
                                pass_s       = 1'b1;
                                busy_s       = 1'b0;
                                tracker_en_s = 1'b0;
                                state_s      = ST_DONE_PASS;
                            end else begin
                                // Next press needs a fresh release first.
                                step_idx_s    = step_idx_r + 4'd1;
                                last_sample_s = 4'd0;
                                stable_cnt_s  = '0;
                                state_s       = ST_WAIT_RELEASE;
                            end
                        end else begin
                            fail_s       = 1'b1;
                            busy_s       = 1'b0;
                            tracker_en_s = 1'b0;
                            state_s      = ST_DONE_FAIL;
                        end
                    end else if (timeout_inc_s >= TIMEOUT_MAX) begin
                        fail_s       = 1'b1;
                        timeout_s    = 1'b1;
                        busy_s       = 1'b0;
                        tracker_en_s = 1'b0;
                        state_s      = ST_DONE_FAIL;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            seq_len_r     <= 5'd0;
            step_idx_r    <= 4'd0;
            last_sample_r <= 4'd0;
            stable_cnt_r  <= '0;
            timeout_cnt_r <= '0;
            busy_r        <= 1'b0;
            tracker_en_r  <= 1'b0;
            press_valid_r <= 1'b0;
            press_color_r <= 2'd0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            seq_len_r     <= seq_len_s;
            step_idx_r    <= step_idx_s;
            last_sample_r <= last_sample_s;
            stable_cnt_r  <= stable_cnt_s;
            timeout_cnt_r <= timeout_cnt_s;
            busy_r        <= busy_s;
            tracker_en_r  <= tracker_en_s;
            press_valid_r <= press_valid_s;
            press_color_r <= press_color_s;
            pass_r        <= pass_s;
            fail_r        <= fail_s;
            timeout_r     <= timeout_s;
        end
    end

    assign tracker_en  = tracker_en_r;
    assign busy        = busy_r;
    assign step_idx    = step_idx_r;
    assign press_valid = press_valid_r;
    assign press_color = press_color_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign timeout     = timeout_r;

endmodule
